// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: grants one of NUM_MANAGERS managers, moving the grant
// only at legal handover points (never mid fixed burst, never while locked, only on hready).
module ahb_arbiter #(
   parameter int NUM_MANAGERS    = 4,
   parameter int HMASTER_WIDTH   = 2,
   parameter int DEFAULT_MANAGER = 0
) (
   input  logic                     hclk,
   input  logic                     hreset,
   input  logic [NUM_MANAGERS-1:0]  hbusreq,
   input  logic [NUM_MANAGERS-1:0]  hlock,
   input  logic [1:0]               htrans,
   input  logic [2:0]               hburst,
   input  logic                     hready,
   input  logic                     hresp,
   output logic [NUM_MANAGERS-1:0]  hgrant,
   output logic [HMASTER_WIDTH-1:0] hmaster,
   output logic                     hmastlock,
   output logic [1:0]               arb_state
);

   typedef enum logic [1:0] {
      PARK   = 2'd0,
      OPEN   = 2'd1,
      BURST  = 2'd2,
      LOCKED = 2'd3
   } state_t;

   localparam int PAD = 2 ** HMASTER_WIDTH;
   localparam logic [HMASTER_WIDTH-1:0] DEF  = HMASTER_WIDTH'(DEFAULT_MANAGER);
   localparam logic [HMASTER_WIDTH-1:0] LAST = HMASTER_WIDTH'(NUM_MANAGERS - 1);

   localparam logic [1:0] T_IDLE   = 2'd0;
   localparam logic [1:0] T_NONSEQ = 2'd2;
   localparam logic [1:0] T_SEQ    = 2'd3;
   localparam logic [2:0] B_SINGLE = 3'd0;
   localparam logic [2:0] B_INCR   = 3'd1;

   state_t                   state, state_next;
   logic [HMASTER_WIDTH-1:0] owner, owner_next;
   logic [3:0]               cnt, cnt_next;

   logic [PAD-1:0]           req_pad, lock_pad;
   logic [HMASTER_WIDTH-1:0] k, rr_idx;
   logic                     rr_found, rearb, beat;
   logic [3:0]               burst_last;

   // Handshake: hready is the bus-wide ready; a beat is accepted only when hready=1 and
   // htrans is NONSEQ or SEQ. Every arbitration decision is frozen while hready=0.
   always_comb begin
      req_pad  = '0;
      lock_pad = '0;
      req_pad[NUM_MANAGERS-1:0]  = hbusreq;
      lock_pad[NUM_MANAGERS-1:0] = hlock & hbusreq;
      beat = hready && htrans[1];
   end

   // Search from owner+1 upward with wrap; the owner itself is visited last.
   always_comb begin
      k        = owner;
      rr_found = 1'b0;
      rr_idx   = owner;
      for (int i = 0; i < NUM_MANAGERS; i++) begin
         k = (k == LAST) ? '0 : k + HMASTER_WIDTH'(1);
         if (!rr_found && req_pad[k]) begin
            rr_found = 1'b1;
            rr_idx   = k;
         end
      end
   end

   always_comb begin
      case (hburst[2:1])
         2'd1:    burst_last = 4'd3;
         2'd2:    burst_last = 4'd7;
         default: burst_last = 4'd15;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state <= PARK;
         owner <= DEF;
         cnt   <= '0;
      end else begin
         state <= state_next;
         owner <= owner_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      owner_next = owner;
      cnt_next   = cnt;
      rearb      = 1'b0;
      if (hready) begin
         if (hresp && state != PARK) begin
            // Second ERROR cycle: drop the burst; the handover waits one cycle.
            cnt_next   = '0;
            state_next = (state == LOCKED && lock_pad[owner]) ? LOCKED : OPEN;
         end else begin
            case (state)
               PARK: rearb = 1'b1;
               OPEN: begin
                  if (beat && htrans == T_NONSEQ && hburst[2:1] != 2'd0) begin
                     state_next = BURST;
                     cnt_next   = burst_last;
                  end else if (htrans == T_IDLE || (beat && hburst == B_SINGLE) ||
                               (hburst == B_INCR && !req_pad[owner])) begin
                     rearb = 1'b1;
                  end
               end
               BURST: begin
                  if (htrans == T_SEQ) begin
                     cnt_next = cnt - 4'd1;
                     if (cnt == 4'd1) rearb = 1'b1;
                  end
               end
               LOCKED: begin
                  if (!lock_pad[owner] && htrans == T_IDLE) rearb = 1'b1;
               end
               default: rearb = 1'b1;
            endcase
         end
      end
      if (rearb) begin
         cnt_next = '0;
         if (rr_found) begin
            owner_next = rr_idx;
            state_next = lock_pad[rr_idx] ? LOCKED : OPEN;
         end else begin
            owner_next = DEF;
            state_next = PARK;
         end
      end
   end

   always_comb begin
      hgrant = '0;
      for (int j = 0; j < NUM_MANAGERS; j++) begin
         hgrant[j] = (owner == HMASTER_WIDTH'(j));
      end
      hmaster   = owner;
      hmastlock = (state == LOCKED);
      arb_state = state;
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: park/grant, burst protection, round-robin order,
// lock hold, ERROR abort and reset mid-burst, all against hand-computed values.
module tb_ahb_arbiter;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] NONSEQ = 2'd2;
   localparam logic [1:0] SEQ    = 2'd3;
   localparam logic [2:0] SINGLE = 3'd0;
   localparam logic [2:0] INCR   = 3'd1;
   localparam logic [2:0] INCR4  = 3'd3;
   localparam logic [2:0] INCR8  = 3'd5;
   localparam logic [2:0] INCR16 = 3'd7;
   localparam logic [1:0] S_PARK = 2'd0, S_OPEN = 2'd1, S_BURST = 2'd2, S_LOCKED = 2'd3;

   logic       hclk = 1'b0;
   logic       hreset = 1'b1;
   logic [3:0] hbusreq = '0;
   logic [3:0] hlock = '0;
   logic [1:0] htrans = IDLE;
   logic [2:0] hburst = SINGLE;
   logic       hready = 1'b1;
   logic       hresp = 1'b0;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic       hmastlock;
   logic [1:0] arb_state;

   int n_checks = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];

   ahb_arbiter #(.NUM_MANAGERS(4), .HMASTER_WIDTH(2), .DEFAULT_MANAGER(0)) dut (
      .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
      .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
      .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock), .arb_state(arb_state)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Apply one cycle of inputs, then sample #1 after the edge that consumed them.
   task automatic drive_cycle(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] trans,
                              input logic [2:0] burst, input logic ready, input logic resp);
      hbusreq = req;
      hlock   = lck;
      htrans  = trans;
      hburst  = burst;
      hready  = ready;
      hresp   = resp;
      @(posedge hclk);
      #1;
   endtask

   task automatic go_park();
      drive_cycle(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
   endtask

   initial begin
      // Reset
      drive_cycle(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
      drive_cycle(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
      hreset = 1'b0;
      check("reset_hgrant", hgrant, 4'b0001);
      check("reset_hmaster", hmaster, 0);
      check("reset_hmastlock", hmastlock, 0);
      check("reset_state", arb_state, S_PARK);

      // Park and grant; a request under hready=0 must not move the grant
      go_park();
      drive_cycle(4'b0100, 4'b0000, IDLE, SINGLE, 1'b0, 1'b0);
      check("park_wait_hmaster", hmaster, 0);
      drive_cycle(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
      check("park_grant_hgrant", hgrant, 4'b0100);
      check("park_grant_hmaster", hmaster, 2);
      check("park_grant_state", arb_state, S_OPEN);
      go_park();
      check("release_state", arb_state, S_PARK);
      check("release_hgrant", hgrant, 4'b0001);

      // Burst protection: M1 INCR4 with M3 requesting and one wait state
      drive_cycle(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
      check("m1_owner", hmaster, 1);
      drive_cycle(4'b0010, 4'b0000, NONSEQ, INCR4, 1'b1, 1'b0);
      check("burst_t_state", arb_state, S_BURST);
      drive_cycle(4'b1010, 4'b0000, SEQ, INCR4, 1'b1, 1'b0);
      check("burst_t1_hmaster", hmaster, 1);
      drive_cycle(4'b1010, 4'b0000, SEQ, INCR4, 1'b0, 1'b0);
      check("burst_t2_hmaster", hmaster, 1);
      drive_cycle(4'b1010, 4'b0000, SEQ, INCR4, 1'b1, 1'b0);
      check("burst_t3_hmaster", hmaster, 1);
      drive_cycle(4'b1010, 4'b0000, SEQ, INCR4, 1'b1, 1'b0);
      check("burst_t5_hmaster", hmaster, 3);
      check("burst_t5_hgrant", hgrant, 4'b1000);
      go_park();

      // Round-robin with all requesting and SINGLE beats
      exp_q = '{1, 2, 3, 0, 1};
      while (exp_q.size() > 0) begin
         drive_cycle(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0);
         check("rr_hmaster", hmaster, exp_q.pop_front());
      end
      go_park();
      check("rr_back_to_park", arb_state, S_PARK);

      // Lock: M2 locked with M0 requesting throughout
      drive_cycle(4'b0101, 4'b0100, IDLE, SINGLE, 1'b1, 1'b0);
      check("lock_grant_hmaster", hmaster, 2);
      check("lock_hmastlock", hmastlock, 1);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(4'b0101, 4'b0100, NONSEQ, SINGLE, 1'b1, 1'b0);
         check("lock_hold_hmaster", hmaster, 2);
         check("lock_hold_hmastlock", hmastlock, 1);
      end
      drive_cycle(4'b0101, 4'b0100, IDLE, SINGLE, 1'b1, 1'b0);
      check("lock_idle_still_held", hmaster, 2);
      drive_cycle(4'b0101, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
      check("unlock_hmaster", hmaster, 0);
      check("unlock_hmastlock", hmastlock, 0);
      check("unlock_state", arb_state, S_OPEN);
      go_park();

      // hlock without hbusreq is ignored
      drive_cycle(4'b0010, 4'b0100, IDLE, SINGLE, 1'b1, 1'b0);
      check("stray_lock_hmaster", hmaster, 1);
      check("stray_lock_hmastlock", hmastlock, 0);
      go_park();

      // ERROR abort: M0 INCR8, two-cycle ERROR on beat 3, M1 requesting
      drive_cycle(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
      check("err_m0_owner", hmaster, 0);
      drive_cycle(4'b0011, 4'b0000, NONSEQ, INCR8, 1'b1, 1'b0);
      drive_cycle(4'b0011, 4'b0000, SEQ, INCR8, 1'b1, 1'b0);
      check("err_beat2_hmaster", hmaster, 0);
      drive_cycle(4'b0011, 4'b0000, SEQ, INCR8, 1'b0, 1'b1);
      check("err_first_cycle_hmaster", hmaster, 0);
      drive_cycle(4'b0011, 4'b0000, IDLE, INCR8, 1'b1, 1'b1);
      check("err_second_cycle_hmaster", hmaster, 0);
      check("err_second_cycle_state", arb_state, S_OPEN);
      drive_cycle(4'b0011, 4'b0000, IDLE, INCR8, 1'b1, 1'b0);
      check("err_handover_hmaster", hmaster, 1);
      drive_cycle(4'b0011, 4'b0000, NONSEQ, INCR, 1'b1, 1'b0);
      check("err_m1_keeps_bus", hmaster, 1);
      go_park();

      // Reset during beat 2 of an INCR16 owned by M2
      drive_cycle(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
      drive_cycle(4'b0100, 4'b0000, NONSEQ, INCR16, 1'b1, 1'b0);
      check("r16_state", arb_state, S_BURST);
      hreset = 1'b1;
      drive_cycle(4'b0100, 4'b0000, SEQ, INCR16, 1'b1, 1'b0);
      hreset = 1'b0;
      check("r16_hgrant", hgrant, 4'b0001);
      check("r16_hmaster", hmaster, 0);
      check("r16_hmastlock", hmastlock, 0);
      check("r16_state_park", arb_state, S_PARK);
      drive_cycle(4'b0010, 4'b0000, SEQ, INCR16, 1'b1, 1'b0);
      check("r16_no_stale_burst", hmaster, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter that shares a single AHB manager port between `NUM_MANAGERS` requesting managers. It sits between the managers and the AHB address/control multiplexer. It drives the per-manager grant, `hmaster` and `hmastlock`, and observes the multiplexed `htrans`/`hburst`/`hready`/`hresp` of the current owner. Grants change only at legal AHB handover points: never inside a fixed-length burst, never during a locked sequence, and only when `hready` is high.

## Interface
- `NUM_MANAGERS`, 4, number of requesting managers (2..16)
- `HMASTER_WIDTH`, 2, width of `hmaster`; must satisfy `2**HMASTER_WIDTH >= NUM_MANAGERS`
- `DEFAULT_MANAGER`, 0, index that is parked on when no manager requests
- `hclk`  in  1  bus clock; all state changes on its rising edge
- `hreset`  in  1  reset; synchronous, active-high
- `hbusreq`  in  NUM_MANAGERS  per-manager bus request
- `hlock`  in  NUM_MANAGERS  per-manager locked-transfer request; qualified by `hbusreq`
- `htrans`  in  2  owner's transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- `hburst`  in  3  owner's burst type (SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7)
- `hready`  in  1  bus ready
- `hresp`  in  1  bus response; 1 = ERROR
- `hgrant`  out  NUM_MANAGERS  one-hot grant, registered
- `hmaster`  out  HMASTER_WIDTH  index of the granted manager, registered
- `hmastlock`  out  1  the current ownership is locked, registered

## Operation
- Reset values:
  - `hgrant` = one-hot(DEFAULT_MANAGER), `hmaster` = DEFAULT_MANAGER, `hmastlock` = 0.
  - Beat counter = 0, RR pointer = DEFAULT_MANAGER, state = PARK.
- Beat accepted: `hready`=1 and `htrans` is NONSEQ or SEQ. BUSY and IDLE never count.
- Burst length from `hburst`, latched on an accepted NONSEQ:
  - SINGLE = 1, 4-beat = 4, 8-beat = 8, 16-beat = 16.
  - INCR = undefined length.
- Round-robin selection:
  - Search starts at (owner+1) mod NUM_MANAGERS and wraps.
  - Lowest index searched first after the pointer.
  - The current owner is chosen last, so it keeps the bus only if no other manager requests.
  - The pointer advances to the new owner on every grant change.
- States:
  - **PARK**: no owner request. Arbitrate every `hready`=1 cycle. Any `hbusreq` bit -> OPEN with that manager, or LOCKED if its `hlock` is set.
  - **OPEN**: owner active with no fixed burst in progress. On an accepted NONSEQ with 4/8/16 burst -> BURST, counter = length-1.
    - On an `hready`=1 cycle with `htrans`=IDLE, or a completed SINGLE beat, or the owner deasserting `hbusreq` during INCR: re-arbitrate.
    - Re-arbitration result: new owner -> OPEN (or LOCKED if its `hlock` is set); no requester -> PARK.
  - **BURST**: decrement the counter on each accepted SEQ. When the counter reaches 0 on an accepted beat, re-arbitrate on that same cycle, exactly as in OPEN.
  - **LOCKED**: `hmastlock`=1. The grant is held regardless of other requests. Exit to re-arbitration on the first `hready`=1 cycle where the owner's `hlock`=0 and `htrans`=IDLE.
- ERROR: `hresp`=1 with `hready`=1 (second ERROR cycle) aborts the burst and clears the counter. State goes to OPEN, or stays LOCKED if the owner's `hlock` is still set. Re-arbitration follows the OPEN rules on the next cycle.
- Grant is never changed while `hready`=0; all decisions wait.
- An `hlock` bit without its `hbusreq` bit is ignored.

## Timing
- Grant latency:
  - Request in cycle n, bus parked, `hready`=1 -> `hgrant`/`hmaster` updated at the edge ending cycle n.
  - The new owner's first address phase is cycle n+1.
- `hgrant`, `hmaster` and `hmastlock` always change on the same edge; no combinational path from inputs to outputs.
- Fixed burst of L beats with no wait states:
  - NONSEQ at cycle t; last beat at t+L-1.
  - Earliest new owner's grant is visible at t+L.
- Each wait state (`hready`=0) delays handover by exactly one cycle.
- Reset asserted mid-burst or mid-lock: all state and outputs return to reset values on the next edge. No partial burst is tracked afterwards.
- Simultaneous handover point and new requests: the new requests take part in that same arbitration.

## Test plan
- Park and grant: reset, then assert `hbusreq`=4'b0100 with `hready`=1 at cycle 5 -> `hgrant`=4'b0100, `hmaster`=2 at cycle 6.
- Burst protection: M1 owns, INCR4 NONSEQ at t, M3 requests at t+1, one wait state at t+2 -> `hgrant` stays M1 through t+4; `hmaster`=3 at t+5.
- Round-robin fairness: all four `hbusreq` held high, SINGLE beats only -> `hmaster` sequence 1,2,3,0,1.
- Lock: M2 has `hlock`=1 with three NONSEQ/SEQ singles, M0 requesting throughout -> `hmastlock`=1 and grant held. Grant moves to M0 one edge after M2 drops `hlock` and drives IDLE.
- ERROR abort: M0 does INCR8, ERROR response on beat 3, M1 requesting -> M1 granted on the edge after the IDLE following the ERROR. M0 is not granted the remaining 5 beats.
- Reset mid-burst: `hreset`=1 during beat 2 of INCR16 -> next edge gives `hgrant`=one-hot(0), `hmaster`=0, `hmastlock`=0, state PARK.
